// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus interface.
//   Groups the request/acknowledge inputs and the per-stage reset/status outputs
//   of the reset sequencer into one bundle.
//   Signals:
//     sw_reset_req  single-cycle request to rerun the full sequence
//     stage_ready   per-stage ready acknowledge, level, clk domain
//     stage_rst     per-stage reset, active high
//     busy          sequence in progress
//     all_ready     all stages released and ready
//     fault         timeout or ready loss detected (sticky until restart)
//     fault_stage   index of the stage that caused the fault
//   Modports:
//     master  the sequencer itself (drives resets and status)
//     slave   the board/subsystem side (drives request and acknowledges)
interface reset_sequencer_if #(
  parameter int N_STAGES = 4
);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic                sw_reset_req;
  logic [N_STAGES-1:0] stage_ready;
  logic [N_STAGES-1:0] stage_rst;
  logic                busy;
  logic                all_ready;
  logic                fault;
  logic [IDX_W-1:0]    fault_stage;

  modport master (
    input  sw_reset_req,
    input  stage_ready,
    output stage_rst,
    output busy,
    output all_ready,
    output fault,
    output fault_stage
  );

  modport slave (
    output sw_reset_req,
    output stage_ready,
    input  stage_rst,
    input  busy,
    input  all_ready,
    input  fault,
    input  fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller.
//   Holds every stage reset asserted for HOLD_CYCLES, then releases stages
//   0..N_STAGES-1 one at a time, waiting (with timeout) for each stage's ready
//   acknowledge and inserting GAP_CYCLES between a ready and the next release.
//   Once all stages are released it watches every ready bit; any loss, or a
//   timeout during sequencing, re-asserts all resets and flags a sticky fault.
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   reset_sequencer_if.master (request, acknowledges, resets, status)
//   All outputs are registered.
module reset_sequencer #(
  parameter int N_STAGES       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  reset_sequencer_if.master   bus
);

  localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  // Counter only ever reaches MAX_ALL-1, so it can never wrap.
  localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_next;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                busy_q, busy_d;
  logic                all_ready_q, all_ready_d;
  logic                fault_q, fault_d;
  logic [IDX_W-1:0]    fault_stage_q, fault_stage_d;

  // Lowest index whose ready bit is low; scanning downward lets the lowest win.
  function automatic logic [IDX_W-1:0] lowest_zero(input logic [N_STAGES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (!v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    busy_d        = busy_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    idx_next      = idx_q + IDX_W'(1);

    if (bus.sw_reset_req) begin
      // Software restart behaves exactly like rst, from any state.
      state_d       = S_HOLD;
      cnt_d         = '0;
      idx_d         = '0;
      stage_rst_d   = '1;
      busy_d        = 1'b1;
      all_ready_d   = 1'b0;
      fault_d       = 1'b0;
      fault_stage_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            stage_rst_d[0] = 1'b0;
            cnt_d          = '0;
            state_d        = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT: begin
          // Ready is checked first so it wins over a simultaneous timeout.
          if (bus.stage_ready[idx_q]) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d     = S_DONE;
              busy_d      = 1'b0;
              all_ready_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d       = S_FAULT;
            stage_rst_d   = '1;
            busy_d        = 1'b0;
            fault_d       = 1'b1;
            fault_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            idx_d                 = idx_next;
            stage_rst_d[idx_next] = 1'b0;
            cnt_d                 = '0;
            state_d               = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          if (!(&bus.stage_ready)) begin
            state_d       = S_FAULT;
            stage_rst_d   = '1;
            all_ready_d   = 1'b0;
            fault_d       = 1'b1;
            fault_stage_d = lowest_zero(bus.stage_ready);
          end
        end

        S_FAULT: begin
          // Sticky: only rst or sw_reset_req leaves this state.
        end

        default: begin
          state_d       = S_FAULT;
          stage_rst_d   = '1;
          busy_d        = 1'b0;
          all_ready_d   = 1'b0;
          fault_d       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      busy_q        <= 1'b1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      busy_q        <= busy_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign bus.stage_rst   = stage_rst_q;
  assign bus.busy        = busy_q;
  assign bus.all_ready   = all_ready_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (N_STAGES=3, HOLD=4, GAP=2, TIMEOUT=8).
// Stimulus drives inputs on the falling edge and, after each rising edge, pushes
// the hand-computed expected outputs into a queue; a monitor pops and compares
// shortly after every rising edge.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer_if #(.N_STAGES(3)) bus ();

  reset_sequencer #(
    .N_STAGES      (3),
    .HOLD_CYCLES   (4),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      nm;
    logic [2:0] srst;
    logic       busy;
    logic       ar;
    logic       flt;
    logic [1:0] fs;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: one pop per rising edge that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.stage_rst !== e.srst || bus.busy !== e.busy || bus.all_ready !== e.ar ||
            bus.fault !== e.flt || bus.fault_stage !== e.fs) begin
          n_bad++;
          $display("FAIL %s @%0t: got rst=%b busy=%b ar=%b fault=%b fs=%0d, want rst=%b busy=%b ar=%b fault=%b fs=%0d",
                   e.nm, $time, bus.stage_rst, bus.busy, bus.all_ready, bus.fault, bus.fault_stage,
                   e.srst, e.busy, e.ar, e.flt, e.fs);
        end
      end
    end
  end

  // One clock: drive inputs, then queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic [2:0] rdy, input logic sw, input string nm,
                      input logic [2:0] e_rst, input logic e_busy, input logic e_ar,
                      input logic e_flt, input logic [1:0] e_fs);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.stage_ready  = rdy;
    bus.sw_reset_req = sw;
    @(posedge clk);
    e.nm = nm; e.srst = e_rst; e.busy = e_busy; e.ar = e_ar; e.flt = e_flt; e.fs = e_fs;
    q.push_back(e);
  endtask

  // stage_rst after edge e of an undisturbed sequence (edge 0 = reset edge).
  function automatic logic [2:0] nom_rst(input int e);
    if (e <= 3)      return 3'b111;
    else if (e <= 6) return 3'b110;
    else if (e <= 9) return 3'b100;
    else             return 3'b000;
  endfunction

  task automatic do_reset(input string nm);
    step(1'b1, 3'b000, 1'b0, nm, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  // Edges 1..11 of a full sequence with all stages ready.
  task automatic nominal(input string nm);
    for (int e = 1; e <= 11; e++)
      step(1'b0, 3'b111, 1'b0, nm, nom_rst(e), (e < 11), (e == 11), 1'b0, 2'd0);
  endtask

  initial begin
    bus.stage_ready  = 3'b000;
    bus.sw_reset_req = 1'b0;

    // 1: nominal sequence, then DONE holds.
    do_reset("reset_state");
    do_reset("reset_state2");
    nominal("nominal");
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'b111, 1'b0, "done_hold", 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);

    // 3: stage_ready[2:1] drop for one cycle in DONE.
    step(1'b0, 3'b001, 1'b0, "done_drop", 3'b111, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b0, 3'b111, 1'b0, "fault_sticky", 3'b111, 1'b0, 1'b0, 1'b1, 2'd1);

    // rst has priority over sw_reset_req.
    step(1'b1, 3'b111, 1'b1, "rst_and_sw", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);

    // 2: stage 1 never ready -> timeout after 8 WAIT cycles.
    for (int e = 1; e <= 6; e++)
      step(1'b0, 3'b101, 1'b0, "to_pre", nom_rst(e), 1'b1, 1'b0, 1'b0, 2'd0);
    for (int e = 7; e <= 14; e++)
      step(1'b0, 3'b101, 1'b0, "to_wait", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'b101, 1'b0, "to_fault", 3'b111, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b0, 3'b111, 1'b0, "to_sticky", 3'b111, 1'b0, 1'b0, 1'b1, 2'd1);

    // 5: sw_reset_req from FAULT clears it and reruns cleanly.
    step(1'b0, 3'b111, 1'b1, "sw_from_fault", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
    nominal("after_fault");

    // 4: sw_reset_req mid-GAP (edge 5 -> GAP with stage_rst=110).
    do_reset("reset_g");
    for (int e = 1; e <= 5; e++)
      step(1'b0, 3'b111, 1'b0, "pre_gap", nom_rst(e), 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'b111, 1'b1, "sw_mid_gap", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
    nominal("rerun");

    // 6: stage_ready[0] rises on the 8th WAIT cycle -> ready beats timeout.
    do_reset("reset_r");
    for (int e = 1; e <= 4; e++)
      step(1'b0, 3'b000, 1'b0, "late_hold", nom_rst(e), 1'b1, 1'b0, 1'b0, 2'd0);
    for (int e = 5; e <= 11; e++)
      step(1'b0, 3'b000, 1'b0, "late_wait", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'b001, 1'b0, "late_ready", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'b001, 1'b0, "late_gap", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'b001, 1'b0, "late_rel1", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
